// File: rtl/user_io_patgen_pkg.sv
// -----------------------------------------------------------------------------
// user_io_patgen_pkg
// Shared definitions for the user IO pattern generator: register offsets,
// the pattern mode encoding, the LFSR tap mask and the pattern helper
// functions used by the step engine.
// -----------------------------------------------------------------------------
package user_io_patgen_pkg;

    localparam int unsigned PAT_FIX_W = 16;

    localparam logic [7:0] ADR_CTRL    = 8'h00;
    localparam logic [7:0] ADR_PERIOD  = 8'h04;
    localparam logic [7:0] ADR_SEED    = 8'h08;
    localparam logic [7:0] ADR_PATTERN = 8'h0C;
    localparam logic [7:0] ADR_CAPTURE = 8'h10;
    localparam logic [7:0] ADR_STEPS   = 8'h14;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        COUNT  = 2'd1,
        LFSR   = 2'd2,
        WALK   = 2'd3
    } patgen_mode_t;

    // Taps at bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // LFSR and walking-one cannot leave the all-zero state, so a zero seed
    // is replaced by a single set bit.
    function automatic logic [15:0] seed_load(input patgen_mode_t m, input logic [15:0] s);
        logic [15:0] r;
        r = s;
        if (((m == LFSR) || (m == WALK)) && (s == 16'h0000)) begin
            r = 16'h0001;
        end
        return r;
    endfunction

    function automatic logic [15:0] pattern_next(input patgen_mode_t m, input logic [15:0] p);
        logic [15:0] r;
        case (m)
            COUNT:   r = p + 16'd1;
            LFSR:    r = {p[14:0], ^(p & LFSR_TAPS)};
            WALK:    r = {p[14:0], p[15]};
            default: r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/user_io_patgen_if.sv
// -----------------------------------------------------------------------------
// user_io_patgen_if
// Wishbone slave bundle between the management bus and the pattern
// generator. Signal names keep the management-side naming (_i into the
// slave, _o out of it).
//   master : drives stb/cyc/we/sel/adr/dat_i, receives ack_o/dat_o
//   slave  : receives stb/cyc/we/sel/adr/dat_i, drives ack_o/dat_o
// -----------------------------------------------------------------------------
interface user_io_patgen_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_io_patgen_step.sv
// -----------------------------------------------------------------------------
// user_io_patgen_step
// Prescaler and pattern sequencer. Holds PATTERN and STEPS.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   en_i             : generator enabled
//   mode_i           : pattern mode
//   load_i           : one-cycle pulse, load the seed and restart the prescaler
//   clr_steps_i      : one-cycle pulse, clear the step counter
//   seed_i, period_i : configuration
//   pattern_o        : current pattern
//   steps_o          : number of pattern steps taken (wraps)
// -----------------------------------------------------------------------------
module user_io_patgen_step
    import user_io_patgen_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  patgen_mode_t mode_i,
    input  logic         load_i,
    input  logic         clr_steps_i,
    input  logic [15:0]  seed_i,
    input  logic [15:0]  period_i,
    output logic [15:0]  pattern_o,
    output logic [31:0]  steps_o
);

    logic [15:0] pattern_q, pattern_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] steps_q, steps_d;
    logic        running;
    logic        step;

    always_comb begin
        running   = en_i && (mode_i != STATIC);
        // ">=" rather than "==" so a PERIOD lowered below the running
        // count fires on the next cycle instead of waiting for a wrap.
        step      = running && !load_i && (presc_q >= period_i);
        pattern_d = pattern_q;
        presc_d   = presc_q;
        steps_d   = steps_q;

        if (mode_i == STATIC) begin
            // Static mode follows SEED whether or not the generator is enabled.
            pattern_d = seed_i;
            presc_d   = '0;
        end else if (load_i) begin
            pattern_d = seed_load(mode_i, seed_i);
            presc_d   = '0;
        end else if (!running) begin
            presc_d   = '0;
        end else if (step) begin
            pattern_d = pattern_next(mode_i, pattern_q);
            presc_d   = '0;
            steps_d   = steps_q + 32'd1;
        end else begin
            presc_d   = presc_q + 16'd1;
        end

        if (clr_steps_i) begin
            steps_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= '0;
            presc_q   <= '0;
            steps_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            presc_q   <= presc_d;
            steps_q   <= steps_d;
        end
    end

    assign pattern_o = pattern_q;
    assign steps_o   = steps_q;

endmodule

// File: rtl/user_io_patgen.sv
// -----------------------------------------------------------------------------
// user_io_patgen
// Wishbone-programmable pad stimulus generator. Drives a 16-bit pattern onto
// io_out[PAT_LSB +: 16] and a status nibble onto io_out[35:32].
//   wb_clk_i : clock
//   resetb   : asynchronous active-low reset
//   wb       : Wishbone slave (user_io_patgen_if.slave)
//   io_in    : pad inputs (sampled only when capture is built in)
//   io_out   : pad outputs
//   io_oeb   : pad output enables, active-low
// Build option: define USER_IO_PATGEN_CAPTURE_EN to include the io_in
// synchroniser and the CAPTURE register; otherwise CAPTURE reads 0.
// -----------------------------------------------------------------------------
module user_io_patgen
    import user_io_patgen_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          PAT_LSB  = 16,
    parameter int          PAT_W    = 16
)(
    input  logic                  wb_clk_i,
    input  logic                  resetb,
    user_io_patgen_if.slave       wb,
    input  logic [37:0]           io_in,
    output logic [37:0]           io_out,
    output logic [37:0]           io_oeb
);

    logic         ack_q, ack_d;
    logic [31:0]  dat_q, dat_d;
    logic         en_q, en_d;
    patgen_mode_t mode_q, mode_d;
    logic [3:0]   status_q, status_d;
    logic         oe_q, oe_d;
    logic [15:0]  period_q, period_d;
    logic [15:0]  seed_q, seed_d;
    logic         load_q, load_d;
    logic         clr_q, clr_d;
    logic [3:0]   pad_status_q;
    logic         pad_oe_q;

    logic         match, acc, wr, rd;
    logic [7:0]   off;
    logic [8:0]   ctrl_cur, ctrl_wr;
    logic [15:0]  period_wr, seed_wr;
    logic [31:0]  rdata;
    logic [31:0]  cap_word;
    logic [15:0]  pattern;
    logic [31:0]  steps;
    logic         unused_bits;

    assign match = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Qualifying with ~ack_q forces a gap between acks.
    assign acc   = wb.wbs_stb_i && wb.wbs_cyc_i && match && !ack_q;
    assign wr    = acc && wb.wbs_we_i;
    assign rd    = acc && !wb.wbs_we_i;
    assign off   = wb.wbs_adr_i[7:0];

    always_comb begin
        ctrl_cur  = {oe_q, status_q, 1'b0, mode_q, en_q};
        ctrl_wr   = ctrl_cur;
        period_wr = period_q;
        seed_wr   = seed_q;
        if (wb.wbs_sel_i[0]) begin
            ctrl_wr[7:0]   = wb.wbs_dat_i[7:0];
            period_wr[7:0] = wb.wbs_dat_i[7:0];
            seed_wr[7:0]   = wb.wbs_dat_i[7:0];
        end
        if (wb.wbs_sel_i[1]) begin
            ctrl_wr[8]      = wb.wbs_dat_i[8];
            period_wr[15:8] = wb.wbs_dat_i[15:8];
            seed_wr[15:8]   = wb.wbs_dat_i[15:8];
        end
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        status_d = status_q;
        oe_d     = oe_q;
        period_d = period_q;
        seed_d   = seed_q;
        load_d   = 1'b0;
        clr_d    = 1'b0;
        if (wr) begin
            case (off)
                ADR_CTRL: begin
                    en_d     = ctrl_wr[0];
                    mode_d   = patgen_mode_t'(ctrl_wr[2:1]);
                    status_d = ctrl_wr[7:4];
                    oe_d     = ctrl_wr[8];
                    // Reload on enable, or on a mode change while already running.
                    load_d   = ctrl_wr[0] && (!en_q || (mode_d != mode_q));
                    clr_d    = ctrl_wr[0] && !en_q;
                end
                ADR_PERIOD: period_d = period_wr;
                ADR_SEED:   seed_d   = seed_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (off)
            ADR_CTRL:    rdata = {23'h0, ctrl_cur};
            ADR_PERIOD:  rdata = {16'h0, period_q};
            ADR_SEED:    rdata = {16'h0, seed_q};
            ADR_PATTERN: rdata = {16'h0, pattern};
            ADR_CAPTURE: rdata = cap_word;
            ADR_STEPS:   rdata = steps;
            default:     rdata = 32'h0;
        endcase
        ack_d = acc;
        dat_d = rd ? rdata : 32'h0;
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            en_q         <= 1'b0;
            mode_q       <= STATIC;
            status_q     <= '0;
            oe_q         <= 1'b0;
            period_q     <= '0;
            seed_q       <= '0;
            load_q       <= 1'b0;
            clr_q        <= 1'b0;
            pad_status_q <= '0;
            pad_oe_q     <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            status_q     <= status_d;
            oe_q         <= oe_d;
            period_q     <= period_d;
            seed_q       <= seed_d;
            load_q       <= load_d;
            clr_q        <= clr_d;
            // Pad copies of the CTRL fields line up with the pattern, which
            // itself lands one cycle after the register write.
            pad_status_q <= status_q;
            pad_oe_q     <= oe_q;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    user_io_patgen_step u_step (
        .clk_i       (wb_clk_i),
        .rst_ni      (resetb),
        .en_i        (en_q),
        .mode_i      (mode_q),
        .load_i      (load_q),
        .clr_steps_i (clr_q),
        .seed_i      (seed_q),
        .period_i    (period_q),
        .pattern_o   (pattern),
        .steps_o     (steps)
    );

`ifdef USER_IO_PATGEN_CAPTURE_EN
    logic [31:0] sync1_q, sync2_q, cap_q;

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cap_q   <= '0;
        end else begin
            sync1_q <= io_in[31:0];
            sync2_q <= sync1_q;
            cap_q   <= sync2_q;
        end
    end

    assign cap_word    = cap_q;
    assign unused_bits = ^{wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2], ctrl_wr[3], io_in[37:32]};
`else
    assign cap_word    = 32'h0;
    assign unused_bits = ^{wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2], ctrl_wr[3], io_in};
`endif

    always_comb begin
        io_out                   = '0;
        io_out[PAT_LSB +: PAT_W] = pattern;
        io_out[35:32]            = pad_status_q;
        io_oeb                   = '1;
        io_oeb[35:16]            = {20{~pad_oe_q}};
    end

endmodule

// File: tb/tb_user_io_patgen.sv
// -----------------------------------------------------------------------------
// tb_user_io_patgen
// Directed bench for user_io_patgen. A time-based model predicts the pads
// every cycle: the pattern is the load value advanced by
// (cycles since load)/(PERIOD+1) steps.
// -----------------------------------------------------------------------------
module tb_user_io_patgen;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        resetb;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    user_io_patgen_if wbif();

    user_io_patgen #(.BASE_ADR(BASE), .PAT_LSB(16), .PAT_W(16)) dut (
        .wb_clk_i (clk),
        .resetb   (resetb),
        .wb       (wbif),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Model state
    logic [15:0] m_seed, m_period, m_pat;
    logic        m_en, m_oe;
    logic [1:0]  m_mode;
    logic [3:0]  m_status;
    logic [31:0] m_steps;
    int          t_load, m_done;
    logic [15:0] ep;
    logic [31:0] rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [15:0] m_next(input logic [1:0] md, input logic [15:0] p);
        case (md)
            2'd1:    m_next = p + 16'd1;
            2'd2:    m_next = {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
            2'd3:    m_next = {p[14:0], p[15]};
            default: m_next = p;
        endcase
    endfunction

    task automatic m_advance(input int lim);
        int target;
        if (m_en && (m_mode != 2'd0)) begin
            target = (lim - t_load) / (int'(m_period) + 1);
            while (m_done < target) begin
                m_pat = m_next(m_mode, m_pat);
                m_done++;
                m_steps++;
            end
        end
    endtask

    task automatic model_reset();
        m_seed = '0; m_period = '0; m_pat = '0; m_en = 1'b0; m_oe = 1'b0;
        m_mode = '0; m_status = '0; m_steps = '0; t_load = 0; m_done = 0;
    endtask

    // Applied one cycle after the acked write edge (t_e0).
    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel, input int t_e0);
        logic [8:0] nw;
        logic       ld, rise;
        case (off)
            8'h00: begin
                nw = {m_oe, m_status, 1'b0, m_mode, m_en};
                if (sel[0]) nw[7:0] = d[7:0];
                if (sel[1]) nw[8]   = d[8];
                m_advance(t_e0);
                ld   = nw[0] && (!m_en || (nw[2:1] != m_mode));
                rise = nw[0] && !m_en;
                m_en = nw[0]; m_mode = nw[2:1]; m_status = nw[7:4]; m_oe = nw[8];
                if (ld) begin
                    m_pat  = ((nw[2:1] >= 2'd2) && (m_seed == 16'h0)) ? 16'h0001 : m_seed;
                    t_load = cyc_cnt;
                    m_done = 0;
                end
                if (rise) m_steps = '0;
            end
            8'h04: begin
                if (sel[0]) m_period[7:0]  = d[7:0];
                if (sel[1]) m_period[15:8] = d[15:8];
            end
            8'h08: begin
                if (sel[0]) m_seed[7:0]  = d[7:0];
                if (sel[1]) m_seed[15:8] = d[15:8];
            end
            default: ;
        endcase
        if (m_mode == 2'd0) m_pat = m_seed;
    endtask

    // Per-cycle pad comparison
    always @(negedge clk) begin
        if (chk_en) begin
            m_advance(cyc_cnt);
            ep = (m_mode == 2'd0) ? m_seed : m_pat;
            check("pads_out", {26'h0, io_out}, {26'h0, 2'b00, m_status, ep, 16'h0000});
            check("pads_oeb", {26'h0, io_oeb}, {26'h0, 2'b11, {20{~m_oe}}, 16'hFFFF});
        end
    end

    task automatic bus_idle();
        wbif.wbs_stb_i = 1'b0; wbif.wbs_cyc_i = 1'b0; wbif.wbs_we_i = 1'b0;
        wbif.wbs_sel_i = 4'h0; wbif.wbs_adr_i = '0;  wbif.wbs_dat_i = '0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        int te0;
        wbif.wbs_adr_i = BASE | {24'h0, off};
        wbif.wbs_dat_i = d; wbif.wbs_sel_i = sel;
        wbif.wbs_we_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        te0 = cyc_cnt;
        check("wr_ack", {63'h0, wbif.wbs_ack_o}, 64'h1);
        bus_idle();
        @(posedge clk); #1;
        check("wr_ack_drop", {63'h0, wbif.wbs_ack_o}, 64'h0);
        model_write(off, d, sel, te0);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
        wbif.wbs_adr_i = BASE | {24'h0, off};
        wbif.wbs_sel_i = 4'hF; wbif.wbs_we_i = 1'b0;
        wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("rd_ack", {63'h0, wbif.wbs_ack_o}, 64'h1);
        d = wbif.wbs_dat_o;
        bus_idle();
        @(posedge clk); #1;
        check("rd_ack_drop", {31'h0, wbif.wbs_ack_o, wbif.wbs_dat_o}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cap;
        resetb = 1'b0;
        io_in  = '0;
        bus_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});
        check("rst_out", {26'h0, io_out}, 64'h0);
        check("rst_ack", {31'h0, wbif.wbs_ack_o, wbif.wbs_dat_o}, 64'h0);
        resetb = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        wb_read(8'h0C, rd); check("rst_pattern", {32'h0, rd}, 64'h0);
        wb_read(8'h14, rd); check("rst_steps", {32'h0, rd}, 64'h0);

        // Non-matching base address: no ack
        wbif.wbs_adr_i = BASE + 32'h100; wbif.wbs_stb_i = 1'b1; wbif.wbs_cyc_i = 1'b1;
        wbif.wbs_we_i = 1'b1; wbif.wbs_sel_i = 4'hF; wbif.wbs_dat_i = 32'h1FF;
        @(posedge clk); #1;
        check("nomatch_ack", {63'h0, wbif.wbs_ack_o}, 64'h0);
        bus_idle();
        @(posedge clk); #1;

        // Static mode plus status
        wb_write(8'h00, 32'h0000_01A0, 4'hF);
        wb_write(8'h08, 32'h0000_1968, 4'hF);
        check("st_status", {60'h0, io_out[35:32]}, 64'hA);
        check("st_pat", {48'h0, io_out[31:16]}, 64'h1968);
        wb_write(8'h08, 32'h0000_1DCD, 4'hF);
        check("st_pat2", {48'h0, io_out[31:16]}, 64'h1DCD);
        wb_write(8'h08, 32'h0000_00FF, 4'b0001);
        check("st_bytesel", {48'h0, io_out[31:16]}, 64'h1DFF);
        wb_write(8'h0C, 32'h0000_5555, 4'hF);
        wb_read(8'h0C, rd); check("st_ro_pattern", {32'h0, rd}, 64'h1DFF);
        wb_read(8'h00, rd); check("st_ctrl_rd", {32'h0, rd}, 64'h1A0);
        wb_read(8'h18, rd); check("unmapped_rd", {32'h0, rd}, 64'h0);
        wb_read(8'h08, rd); check("seed_rd", {32'h0, rd}, 64'h1DFF);

        // Counter, PERIOD=0
        wb_write(8'h08, 32'h0000_AB40, 4'hF);
        wb_write(8'h04, 32'h0000_0000, 4'hF);
        wb_write(8'h00, 32'h0000_0103, 4'hF);
        check("cnt_load", {48'h0, io_out[31:16]}, 64'hAB40);
        @(posedge clk); #1;
        check("cnt_step1", {48'h0, io_out[31:16]}, 64'hAB41);
        repeat (8) @(posedge clk);
        #1;
        wb_write(8'h00, 32'h0000_0102, 4'hF);
        wb_read(8'h14, rd);
        check("cnt_steps", {32'h0, rd}, 64'd10);
        check("cnt_steps_model", {32'h0, rd}, {32'h0, m_steps});
        wb_read(8'h0C, rd); check("cnt_pattern", {32'h0, rd}, 64'hAB4A);

        // LFSR, zero seed, PERIOD=3
        wb_write(8'h08, 32'h0000_0000, 4'hF);
        wb_write(8'h04, 32'h0000_0003, 4'hF);
        wb_write(8'h00, 32'h0000_0105, 4'hF);
        check("lfsr_load", {48'h0, io_out[31:16]}, 64'h0001);
        repeat (4) @(posedge clk);
        #1;
        check("lfsr_step1", {48'h0, io_out[31:16]}, 64'h0002);
        repeat (4) @(posedge clk);
        #1;
        check("lfsr_step2", {48'h0, io_out[31:16]}, 64'h0004);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            check("lfsr_nonzero", {63'h0, (io_out[31:16] == 16'h0)}, 64'h0);
        end
        wb_write(8'h00, 32'h0000_0104, 4'hF);

        // Walking one, wrap, hold, re-enable
        wb_write(8'h08, 32'h0000_8000, 4'hF);
        wb_write(8'h04, 32'h0000_0001, 4'hF);
        wb_write(8'h00, 32'h0000_0107, 4'hF);
        check("walk_load", {48'h0, io_out[31:16]}, 64'h8000);
        repeat (2) @(posedge clk);
        #1;
        check("walk_wrap", {48'h0, io_out[31:16]}, 64'h0001);
        wb_write(8'h00, 32'h0000_0106, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("walk_hold", {48'h0, io_out[31:16]}, 64'h0001);
        wb_read(8'h14, rd); check("walk_steps_held", {32'h0, rd}, 64'd1);
        wb_write(8'h00, 32'h0000_0107, 4'hF);
        check("walk_reload", {48'h0, io_out[31:16]}, 64'h8000);
        wb_read(8'h14, rd); check("walk_steps_clr", {32'h0, rd}, 64'd0);

        // Capture
        io_in = 38'h2A_5A5A_1234;
        repeat (4) @(posedge clk);
        #1;
        wb_read(8'h10, rd);
`ifdef USER_IO_PATGEN_CAPTURE_EN
        exp_cap = 32'h5A5A_1234;
`else
        exp_cap = 32'h0;
`endif
        check("capture", {32'h0, rd}, {32'h0, exp_cap});

        // Asynchronous reset mid-run
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b0;
        resetb = 1'b0;
        #1;
        check("arst_out", {26'h0, io_out}, 64'h0);
        check("arst_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});
        check("arst_ack", {63'h0, wbif.wbs_ack_o}, 64'h0);
        model_reset();
        @(posedge clk); #1;
        resetb = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wb_read(8'h00, rd); check("arst_ctrl", {32'h0, rd}, 64'h0);
        wb_read(8'h14, rd); check("arst_steps", {32'h0, rd}, 64'h0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/user_io_patgen.md
# user_io_patgen

Wishbone-programmable stimulus generator in the user project area, directly upstream of the chip-level IO stimulus testbench. It drives the user-controlled pad field `io_out[31:16]` (pattern) and `io_out[35:32]` (status nibble) with static, counting, LFSR or walking-one sequences. Firmware configures it over the management Wishbone bus. It optionally samples `io_in` back for loopback checks.

## Interface
- `BASE_ADR`, default 32'h3000_0000: Wishbone base address. Decode uses `wbs_adr_i[31:8]`.
- `PAT_LSB`, default 16: LSB of the pattern field on the pads.
- `PAT_W`, default 16: pattern width. Must be 16; the LFSR taps are fixed.
- `wb_clk_i`  in  1: single clock.
- `resetb`  in  1: reset, asynchronous assert, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each: Wishbone strobe, cycle, write.
- `wbs_sel_i`  in  4: byte enables.
- `wbs_adr_i`  in  32: address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: acknowledge.
- `wbs_dat_o`  out  32: read data.
- `io_in`  in  38: pad inputs.
- `io_out`  out  38: pad outputs.
- `io_oeb`  out  38: pad output-enable, active-low.

## Operation
Registers, at byte offsets from `BASE_ADR`:
- 0x00 CTRL, RW: [0] EN, [2:1] MODE (0 static, 1 count, 2 LFSR, 3 walk), [7:4] STATUS nibble, [8] OE.
- 0x04 PERIOD, RW [15:0]: the pattern steps every PERIOD+1 cycles.
- 0x08 SEED, RW [15:0].
- 0x0C PATTERN, RO [15:0]: current pattern.
- 0x10 CAPTURE, RO: synchronised `io_in[31:0]`.
- 0x14 STEPS, RO 32-bit: step count. Wraps at 2^32. Cleared on EN rising.

Register writes:
- Honour `wbs_sel_i` per byte.
- Reads of unmapped offsets return 0.
- Writes to RO registers are ignored.

Pattern behaviour:
- MODE 0: PATTERN tracks SEED continuously. No steps; STEPS stays 0.
- MODE 1: PATTERN = PATTERN+1, modulo 2^16.
- MODE 2: Fibonacci LFSR x^16+x^14+x^13+x^11+1. Next = {P[14:0], P[15]^P[13]^P[12]^P[10]}. A seed of 0 loads as 16'h0001.
- MODE 3: rotate left by 1. A seed of 0 loads as 16'h0001.
- On EN 0→1, or on a CTRL write that changes MODE while EN=1: PATTERN ← SEED (with the zero-seed rule) and the prescaler clears.
- SEED writes while running in modes 1–3 take effect only at the next load.
- On EN 1→0: PATTERN and STEPS hold their values. The prescaler clears.
- PERIOD writes while running: the new value applies at the next prescaler reload. If the prescaler count exceeds the new PERIOD, the step fires on the next cycle.

Pad mapping:
- `io_out[PAT_LSB+:16]` = PATTERN.
- `io_out[35:32]` = STATUS.
- All other `io_out` bits are 0.
- `io_oeb[35:16]` = ~OE. All other `io_oeb` bits are 1.

## Timing
- Reset values: all registers 0, prescaler 0, `wbs_ack_o`=0, `wbs_dat_o`=0, `io_out`=0, `io_oeb`=all 1.
- Wishbone:
  - The ack is registered and asserts the cycle after `stb&cyc&match`.
  - The ack lasts 1 cycle.
  - No back-to-back ack: the strobe must be seen with ack low.
  - Read data is valid with the ack.
- A register write is visible on the pads the cycle after the ack.
- The seed load on EN rising occurs in the cycle after the write ack.
- The first step comes PERIOD+1 cycles after the load.
- STEPS increments in the same cycle as the PATTERN update.
- CAPTURE latency is 3 cycles: 2-flop synchroniser plus a register.
- Reset asserted mid-operation returns every output to its reset value immediately, since reset is asynchronous.

## Configuration
- `USER_IO_PATGEN_CAPTURE_EN` defined: CAPTURE is implemented (synchroniser plus 32-bit register).
- Undefined: no capture flops; offset 0x10 reads 0; `io_in` is unused.

## Structure
- Package `user_io_patgen_pkg` holds:
  - register offset constants `ADR_CTRL` … `ADR_STEPS`;
  - the mode enum `patgen_mode_t` (STATIC, COUNT, LFSR, WALK);
  - the LFSR tap mask 16'hB400 (taps at bits 15,13,12,10).
- One sub-module, `user_io_patgen_step`: the prescaler plus next-pattern function (mode, load, step enable, PATTERN, STEPS).
- The top level holds the Wishbone decode, the registers and the pad mapping.

## Test plan
- Reset: release `resetb` → `io_oeb`=38'h3F_FFFF_FFFF, `io_out`=0. Read 0x0C → 0.
- Counter: SEED=0xAB40, PERIOD=0, CTRL=0x103 →
  - pads [31:16] show 0xAB40 then 0xAB41 on the next cycle;
  - STEPS=N after N steps.
- Static plus status: CTRL=0x1A0, SEED=0x1968 → `io_out[35:32]`=4'hA and `io_out[31:16]`=0x1968. Rewriting SEED=0x1DCD updates the pads 1 cycle after the ack.
- LFSR: SEED=0, PERIOD=3, MODE=2, EN=1 → loads 0x0001, then 0x0002 four cycles later, then 0x0004. Zero is never reached.
- Walk plus disable: SEED=0x8000, MODE=3 → 0x8000 then 0x0001 (wrap). Clearing EN holds the pattern. Setting EN again reloads 0x8000 and STEPS=0.
- Capture (macro on): drive `io_in[31:0]`=0x5A5A_1234 → CAPTURE reads 0x5A5A_1234 three or more cycles later. With the macro off, it reads 0.
